seq_gen_1111: RTL and testbench

- Serial pattern transmitter; the source end of the single-bit serial line that our sequence detectors monitor.
- Accepts a parallel word plus repeat and gap settings on a start pulse.
- Shifts the word out MSB-first on a registered serial output, repeating it with optional idle-zero gaps.
- Used as the stimulus/driver side for the "1111" detector in system builds and benches.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_piso.sv | 24 ++
 rtl/seq_gen_1111.sv | 96 +++++++++
 tb/tb_seq_gen_1111.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared constants for the serial pattern driver and the "1111" detector
package seq_pkg;
    localparam int W_DEF  = 8;
    localparam int CW_DEF = 4;

    // Driver FSM, one-hot
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SEND = 4'b0010,
        GAP  = 4'b0100,
        FIN  = 4'b1000
    } gen_state_t;

    // Detector FSM: number of consecutive ones seen, saturating at four
    typedef enum logic [2:0] {
        D_S0 = 3'd0,
        D_S1 = 3'd1,
        D_S2 = 3'd2,
        D_S3 = 3'd3,
        D_S4 = 3'd4
    } det_state_t;
endpackage

// File: rtl/seq_piso.sv
// seq_piso: W-bit parallel-in serial-out shift register, MSB first
// Ports: clk, rst (async active-low), load (capture d), shift (shift left),
//        d (parallel word), msb_next (MSB the register will present after this edge)
module seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb_next
);
    logic [W-1:0] sr;

    // Look-ahead lets the caller register the serial bit on the same edge as the shift
    assign msb_next = load ? d[W-1] : shift ? sr[W-2] : sr[W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr <= '0;
        else if (load) sr <= d;
        else if (shift) sr <= {sr[W-2:0], 1'b0};
    end
endmodule

// File: rtl/seq_gen_1111.sv
// seq_gen_1111: serial pattern transmitter driving the "1111" detector line
// Ports: clk, rst (async active-low); start/din/rep/gap request a transfer in IDLE;
//        ready (idle), x (serial bit), x_valid (x is a pattern bit), done (one-cycle end pulse)
module seq_gen_1111
    import seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic [CW-1:0] rep,
    input  logic [CW-1:0] gap,
    output logic          ready,
    output logic          x,
    output logic          x_valid,
    output logic          done
);
    localparam int BW = $clog2(W);

    gen_state_t    state, nxt;
    logic [W-1:0]  word;
    logic [CW-1:0] rep_l, gap_l, rcnt, gcnt;
    logic [BW-1:0] bcnt;
    logic          load, shift, last, more, bit_nxt;

    assign last = bcnt == BW'(W - 1);
    // Compared against the latched count, so rep = all-ones never relies on wrap
    assign more = rcnt < rep_l;

    always_comb begin
        nxt   = IDLE;
        load  = 1'b0;
        shift = 1'b0;
        case (state)
            IDLE: begin
                nxt  = start ? SEND : IDLE;
                load = start;
            end
            SEND: begin
                nxt   = !last ? SEND : !more ? FIN : (gap_l != '0) ? GAP : SEND;
                shift = !last;
                load  = last && more && gap_l == '0;
            end
            GAP: begin
                nxt  = (gcnt == gap_l - CW'(1)) ? SEND : GAP;
                load = gcnt == gap_l - CW'(1);
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    seq_piso #(.W(W)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .d        (state == IDLE ? din : word),
        .msb_next (bit_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            word    <= '0;
            rep_l   <= '0;
            gap_l   <= '0;
            rcnt    <= '0;
            gcnt    <= '0;
            bcnt    <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state   <= nxt;
            x       <= (nxt == SEND) && bit_nxt;
            x_valid <= nxt == SEND;
            done    <= nxt == FIN;
            ready   <= nxt == IDLE;
            bcnt    <= load ? '0 : shift ? bcnt + BW'(1) : bcnt;
            gcnt    <= (state == GAP) ? gcnt + CW'(1) : '0;
            if (state == IDLE && start) begin
                word  <= din;
                rep_l <= rep;
                gap_l <= gap;
                rcnt  <= '0;
            end else if (state == SEND && last && more) begin
                rcnt <= rcnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_gen_1111.sv
// tb_seq_gen_1111: directed-vector bench for the serial pattern transmitter
module tb_seq_gen_1111;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] rep = '0;
    logic [3:0] gap = '0;
    logic       ready, x, x_valid, done;
    int         vectors = 0;
    int         errors = 0;

    det_state_t det = D_S0;
    logic       z;

    seq_gen_1111 #(.W(8), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .rep     (rep),
        .gap     (gap),
        .ready   (ready),
        .x       (x),
        .x_valid (x_valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference "1111" detector watching the serial line
    always @(posedge clk) begin
        if (!x) det <= D_S0;
        else case (det)
            D_S0:    det <= D_S1;
            D_S1:    det <= D_S2;
            D_S2:    det <= D_S3;
            default: det <= D_S4;
        endcase
    end
    assign z = det == D_S4;

    task automatic issue(input logic [7:0] w, input logic [3:0] r, input logic [3:0] g);
        @(negedge clk);
        din = w; rep = r; gap = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0; din = ~w; rep = ~r; gap = ~g;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (x !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: x=%b xv=%b done=%b ready=%b, want 0 0 0 1", x, x_valid, done, ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || x_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b xv=%b, want 1 0", ready, x_valid);
        end
    endtask

    task automatic test_basic(input string tag);
        logic [7:0] w = 8'hF0;
        issue(w, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (x !== w[7-i] || x_valid !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: x=%b xv=%b ready=%b done=%b, want %b 1 0 0", tag, i, x, x_valid, ready, done, w[7-i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (done !== 1'b1 || x !== 1'b0 || x_valid !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s fin: done=%b x=%b xv=%b ready=%b, want 1 0 0 0", tag, done, x, x_valid, ready);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: done=%b ready=%b, want 0 1", tag, done, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ws [2] = '{8'hA5, 8'h81};
        int         rs [2] = '{2, 15};
        for (int k = 0; k < 2; k++) begin
            logic [7:0] w = ws[k];
            issue(w, 4'(rs[k]), 4'd0);
            for (int r = 0; r <= rs[k]; r++) begin
                for (int i = 0; i < 8; i++) begin
                    vectors++;
                    if (x !== w[7-i] || x_valid !== 1'b1 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b%0d rep%0d bit%0d: x=%b xv=%b done=%b, want %b 1 0", k, r, i, x, x_valid, done, w[7-i]);
                    end
                    @(negedge clk);
                end
            end
            vectors++;
            if (done !== 1'b1 || x_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d fin: done=%b xv=%b, want 1 0", k, done, x_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] w = 8'h0F;
        issue(w, 4'd1, 4'd3);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (x !== w[7-i] || x_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL gap rep%0d bit%0d: x=%b xv=%b, want %b 1", r, i, x, x_valid, w[7-i]);
                end
                @(negedge clk);
            end
            if (r == 0) begin
                for (int g = 0; g < 3; g++) begin
                    vectors++;
                    if (x !== 1'b0 || x_valid !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL gap idle%0d: x=%b xv=%b ready=%b done=%b, want 0 0 0 0", g, x, x_valid, ready, done);
                    end
                    @(negedge clk);
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || x_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap fin: done=%b xv=%b, want 1 0", done, x_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_detector();
        issue(8'hFF, 4'd0, 4'd0);
        for (int c = 0; c < 11; c++) begin
            logic want = (c >= 4 && c <= 8);
            vectors++;
            if (z !== want) begin
                errors++;
                $display("FAIL detect cyc%0d: z=%b want %b (x=%b)", c, z, want, x);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_held();
        int n = 0;
        @(negedge clk);
        din = 8'hF0; rep = 4'd0; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 9; c++) begin
            vectors++;
            if (ready !== 1'b0 || done !== (c == 8)) begin
                errors++;
                $display("FAIL held cyc%0d: ready=%b done=%b, want 0 %b", c, ready, done, c == 8);
            end
            @(negedge clk);
        end
        vectors++;
        if (ready !== 1'b1 || x_valid !== 1'b0) begin
            errors++;
            $display("FAIL held idle: ready=%b xv=%b, want 1 0", ready, x_valid);
        end
        @(negedge clk);
        vectors++;
        if (x_valid !== 1'b1 || x !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL held restart: xv=%b x=%b ready=%b, want 1 1 0", x_valid, x, ready);
        end
        start = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 8) begin
            errors++;
            $display("FAIL held second_len: done after %0d cycles, want 8", n);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        issue(8'hFF, 4'd1, 4'd2);
        repeat (13) @(negedge clk);
        vectors++;
        if (x !== 1'b1 || x_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: x=%b xv=%b, want 1 1", x, x_valid);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (x !== 1'b0 || x_valid !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst async: x=%b xv=%b ready=%b done=%b, want 0 0 1 0", x, x_valid, ready, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || x_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst quiet%0d: done=%b xv=%b, want 0 0", c, done, x_valid);
            end
        end
        test_basic("after_rst");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_back_to_back();
        test_gaps();
        test_detector();
        test_start_held();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
